fft_bf_scheduler: RTL and testbench

Sequencing controller for a single shared radix-2 butterfly performing an in-place, decimation-in-time N-point FFT over an external dual-port working memory. Once started, it walks all log2(N) stages, issuing one butterfly pair per cycle as read addresses plus a twiddle index. It tracks the two-cycle read/compute pipeline so write-back addresses line up with butterfly outputs, and inserts drain bubbles between stages to avoid read-after-write hazards. Input data is already bit-reverse ordered in memory when `start` is asserted.

---
 rtl/fft_bf_scheduler.sv | 127 ++++++++++++
 tb/tb_fft_bf_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bf_scheduler.sv
// Radix-2 DIT FFT butterfly scheduler: walks log2(N) stages over an in-place
// dual-port memory, issuing one pair per cycle and tracking write-back.
module fft_bf_scheduler #(
  parameter int N = 8,
  parameter int LOG2N = 3,
  localparam int SW = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1,
  localparam int PW = LOG2N - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [PW-1:0]    tw_idx,
  output logic [SW-1:0]    stage,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  localparam logic [PW-1:0] LAST_P = PW'(N / 2 - 1);
  localparam logic [SW-1:0] LAST_S = SW'(LOG2N - 1);

  state_t          state;
  logic [PW-1:0]   p;
  logic [SW-1:0]   s;
  logic            cnt;

  logic             v1;
  logic [LOG2N-1:0] a1;
  logic [LOG2N-1:0] b1;

  logic [LOG2N-1:0] pw;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] a_n;
  logic [LOG2N-1:0] b_n;
  logic [PW-1:0]    tw_n;

  // Address A is p with a zero bit inserted at position s.
  always_comb begin
    pw   = {1'b0, p};
    span = {{(LOG2N-1){1'b0}}, 1'b1} << s;
    pos  = pw & (span - 1'b1);
    a_n  = (((pw >> s) << 1) << s) | pos;
    b_n  = a_n | span;
    tw_n = pos[PW-1:0] << (LAST_S - s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p         <= '0;
      s         <= '0;
      cnt       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      stage     <= '0;
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      busy      <= state != IDLE;
      done      <= busy && state == IDLE;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      stage     <= '0;
      v1        <= rd_en;
      a1        <= rd_addr_a;
      b1        <= rd_addr_b;
      wr_en     <= v1;
      wr_addr_a <= a1;
      wr_addr_b <= b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            p     <= '0;
            s     <= '0;
          end
        end
        ISSUE: begin
          if (!stall) begin
            rd_en     <= 1'b1;
            rd_addr_a <= a_n;
            rd_addr_b <= b_n;
            tw_idx    <= tw_n;
            stage     <= s;
            p         <= p + 1'b1;
            cnt       <= 1'b0;
            if (p == LAST_P)
              state <= (s == LAST_S) ? FLUSH : DRAIN;
          end
        end
        DRAIN: begin
          cnt <= ~cnt;
          if (cnt) begin
            state <= ISSUE;
            s     <= s + 1'b1;
            p     <= '0;
          end
        end
        FLUSH: begin
          cnt <= ~cnt;
          if (cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Directed bench for fft_bf_scheduler: schedule, timing, stall, reset,
// back-to-back starts and an end-to-end FFT through a behavioural memory.
module tb_fft_bf_scheduler;

  localparam int N = 8;
  localparam int LOG2N = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_idx;
  logic [1:0] stage;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;

  fft_bf_scheduler #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .stage(stage), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int a; int b; int k; int s; } ev_t;
  typedef struct { int a; int b; real xr; real xi; real yr; real yi; } bf_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  done_c[$];
  int  busy_c[$];
  bf_t pend[$];

  int  ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int  eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int  ek [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int  edge_n = 0;
  int  t0 = 0;
  int  errors = 0;
  int  checks = 0;
  int  zv = 0;
  int  hz = 0;
  int  bad_wr = 0;
  bit  e2e = 1'b0;
  real mre [N];
  real mim [N];

  int  rel, ra, rb, wa, wb;
  real ang, wre, wim, tr, ti;
  bf_t bf;

  always @(posedge clk) edge_n++;

  // Observer: logs strobes and, when enabled, runs the butterfly datapath.
  always @(posedge clk) begin
    #1;
    rel = edge_n - t0;
    if (rd_en) begin
      ra = int'(rd_addr_a);
      rb = int'(rd_addr_b);
      rdq.push_back(ev_t'{rel, ra, rb, int'(tw_idx), int'(stage)});
      if (e2e) begin
        foreach (pend[j])
          if (pend[j].a == ra || pend[j].a == rb ||
              pend[j].b == ra || pend[j].b == rb) hz++;
        ang = -2.0 * 3.14159265358979 * real'(int'(tw_idx)) / real'(N);
        wre = $cos(ang);
        wim = $sin(ang);
        tr  = wre * mre[rb] - wim * mim[rb];
        ti  = wre * mim[rb] + wim * mre[rb];
        pend.push_back(bf_t'{ra, rb, mre[ra] + tr, mim[ra] + ti,
                             mre[ra] - tr, mim[ra] - ti});
      end
    end else if (rd_addr_a != 0 || rd_addr_b != 0 || tw_idx != 0 || stage != 0) begin
      zv++;
    end
    if (wr_en) begin
      wa = int'(wr_addr_a);
      wb = int'(wr_addr_b);
      wrq.push_back(ev_t'{rel, wa, wb, 0, 0});
      if (e2e) begin
        if (pend.size() == 0) begin
          bad_wr++;
        end else begin
          bf = pend.pop_front();
          if (bf.a != wa || bf.b != wb) bad_wr++;
          mre[wa] = bf.xr;
          mim[wa] = bf.xi;
          mre[wb] = bf.yr;
          mim[wb] = bf.yi;
        end
      end
    end else if (wr_addr_a != 0 || wr_addr_b != 0) begin
      zv++;
    end
    if (done) done_c.push_back(rel);
    if (busy) busy_c.push_back(rel);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input ev_t e);
    return 32'((e.c << 16) | (e.a << 12) | (e.b << 8) | (e.k << 4) | e.s);
  endfunction

  function automatic logic [31:0] outs();
    return {12'd0, busy, done, rd_en, wr_en, stage, rd_addr_a, rd_addr_b,
            tw_idx, wr_addr_a, wr_addr_b};
  endfunction

  task automatic at_cyc(input int c);
    int g;
    g = 0;
    while (edge_n - t0 < c && g < 500) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic go(input bit held);
    rdq.delete();
    wrq.delete();
    done_c.delete();
    busy_c.delete();
    start = 1'b1;
    t0 = edge_n + 1;
    if (!held) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    while (done_c.size() < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", done_c.size(), n);
    repeat (3) @(negedge clk);
  endtask

  // Pair i issues at 1+6*stage+i%4, shifted by d cycles from pair d_from on.
  task automatic check_seq(input string tag, input int base, input int off,
                           input int d_from, input int d);
    int c;
    for (int i = 0; i < 12; i++) begin
      if (base + i >= rdq.size() || base + i >= wrq.size()) begin
        check($sformatf("%s_missing%0d", tag, i), 0, 1);
        break;
      end
      c = off + 1 + 6 * (i / 4) + (i % 4) + ((i >= d_from) ? d : 0);
      check($sformatf("%s_rd%0d", tag, i), pk(rdq[base + i]),
            pk(ev_t'{c, ea[i], eb[i], ek[i], i / 4}));
      check($sformatf("%s_wr%0d", tag, i), pk(wrq[base + i]),
            pk(ev_t'{c + 2, ea[i], eb[i], 0, 0}));
    end
  endtask

  task automatic run_e2e(input string tag, input bit ones);
    for (int j = 0; j < N; j++) begin
      mre[j] = (ones || j == 0) ? 1.0 : 0.0;
      mim[j] = 0.0;
    end
    pend.delete();
    hz = 0;
    bad_wr = 0;
    e2e = 1'b1;
    go(1'b0);
    wait_done(1);
    e2e = 1'b0;
    for (int j = 0; j < N; j++) begin
      check($sformatf("%s_re%0d", tag, j), int'(mre[j] * 1000.0),
            ones ? ((j == 0) ? 8000 : 0) : 1000);
      check($sformatf("%s_im%0d", tag, j), int'(mim[j] * 1000.0), 0);
    end
    check({tag, "_hazard"}, hz, 0);
    check({tag, "_wb_order"}, bad_wr, 0);
    check({tag, "_pending"}, pend.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_out", outs(), 0);

    // basic run with impulse data
    run_e2e("imp", 1'b0);
    check_seq("basic", 0, 0, 12, 0);
    check("basic_nrd", rdq.size(), 12);
    check("basic_done", done_c[0], 19);
    check("basic_busy_n", busy_c.size(), 18);
    check("basic_busy_first", busy_c[0], 1);
    check("basic_busy_last", busy_c[$], 18);

    run_e2e("ones", 1'b1);

    // stall for 3 cycles at stage 1 pair 2
    go(1'b0);
    at_cyc(8);
    stall = 1'b1;
    at_cyc(11);
    stall = 1'b0;
    wait_done(1);
    check_seq("stall", 0, 0, 6, 3);
    check("stall_nrd", rdq.size(), 12);
    check("stall_done", done_c[0], 22);

    // stall during drain and flush is ignored
    go(1'b0);
    at_cyc(4);
    stall = 1'b1;
    at_cyc(6);
    stall = 1'b0;
    at_cyc(16);
    stall = 1'b1;
    at_cyc(18);
    stall = 1'b0;
    wait_done(1);
    check_seq("dstall", 0, 0, 12, 0);
    check("dstall_done", done_c[0], 19);

    // reset in the middle of stage 1
    go(1'b0);
    at_cyc(9);
    reset = 1'b1;
    at_cyc(10);
    check("rst_mid_out", outs(), 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_nrd", rdq.size(), 7);
    check("rst_nwr", wrq.size(), 5);
    check("rst_last_wr", wrq[$].c, 9);
    check("rst_ndone", done_c.size(), 0);
    check("rst_nbusy", busy_c.size(), 9);
    check("rst_idle_out", outs(), 0);
    go(1'b0);
    wait_done(1);
    check_seq("fresh", 0, 0, 12, 0);
    check("fresh_done", done_c[0], 19);

    // start held high: back-to-back transforms
    go(1'b1);
    at_cyc(25);
    start = 1'b0;
    wait_done(2);
    check("b2b_nrd", rdq.size(), 24);
    check_seq("b2b_first", 0, 0, 12, 0);
    check_seq("b2b_second", 12, 19, 12, 0);
    check("b2b_done0", done_c[0], 19);
    check("b2b_done1", done_c[1], 38);
    check("b2b_nbusy", busy_c.size(), 36);

    check("strobe_zero", zv, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
